// File: rtl/cnn_stream.sv
// Streaming 3x3 "valid" convolution over an IMG_H x IMG_W raster frame.
// Result = saturate((sum of nine pixel*coef products) >> SHIFT) to OUT_W bits.
module cnn_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int SHIFT  = 8,
  parameter int B11 = 219, parameter int B12 = 181, parameter int B13 = 130,
  parameter int B21 = 201, parameter int B22 = 81,  parameter int B23 = 34,
  parameter int B31 = 63,  parameter int B32 = 11,  parameter int B33 = 199
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 4;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  // Handshake: a beat transfers on a rising edge where valid && ready. The whole
  // pipeline (window, counters, both stages) moves only when advance is high, so
  // a stalled result holds y and blocks new pixels until it is consumed.
  logic advance, accept, win_ok, last_px, coef_ok;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COEF_W-1:0] coef_q [9];
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [PROD_W-1:0] prod_q [9];
  logic [PROD_W-1:0] prod_d [9];
  logic              s1_valid_q, s1_last_q, y_valid_q, y_last_q;
  logic [OUT_W-1:0]  y_q, y_d;
  logic [SUM_W-1:0]  sum, sum_sh;

  assign advance    = !y_valid_q || y_ready;
  assign accept     = x_valid && advance;
  assign win_ok     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign last_px    = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign busy       = (row_q != '0) || (col_q != '0) || s1_valid_q || y_valid_q;
  assign coef_ok    = coef_we && !busy && (coef_addr < 4'd9);
  assign x_ready    = advance;
  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign frame_done = y_valid_q && y_ready && y_last_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Window rows are oldest line (top) to incoming line (bottom); column 2 is newest.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r*3]     = win_q[r*3+1];
      win_d[r*3+1]   = win_q[r*3+2];
      win_d[r*3+2]   = '0;
    end
    win_d[2] = lb0_q[col_q];
    win_d[5] = lb1_q[col_q];
    win_d[8] = x;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PROD_W'(win_d[i]) * PROD_W'(coef_q[i]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + SUM_W'(prod_q[i]);
    end
    sum_sh = sum >> SHIFT;
    y_d    = (|sum_sh[SUM_W-1:OUT_W]) ? '1 : sum_sh[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      y_q        <= '0;
      coef_q[0]  <= COEF_W'(B11);
      coef_q[1]  <= COEF_W'(B12);
      coef_q[2]  <= COEF_W'(B13);
      coef_q[3]  <= COEF_W'(B21);
      coef_q[4]  <= COEF_W'(B22);
      coef_q[5]  <= COEF_W'(B23);
      coef_q[6]  <= COEF_W'(B31);
      coef_q[7]  <= COEF_W'(B32);
      coef_q[8]  <= COEF_W'(B33);
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (advance) begin
        s1_valid_q <= accept && win_ok;
        s1_last_q  <= accept && last_px;
        y_valid_q  <= s1_valid_q;
        y_last_q   <= s1_last_q;
        if (s1_valid_q) y_q <= y_d;
      end
      if (coef_ok) coef_q[coef_addr] <= coef_data;
    end
  end

  // Data-only storage; its contents are qualified by the counters and valid bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= x;
      win_q        <= win_d;
      prod_q       <= prod_d;
    end
  end

endmodule

// File: tb/tb_cnn_stream.sv
// Directed bench for cnn_stream: default/saturating/loaded coefficients,
// backpressure, ignored writes, back-to-back frames and mid-frame reset.
module tb_cnn_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] x = '0;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic       coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready = 1'b1;
  logic       busy;
  logic       frame_done;

  cnn_stream dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .busy(busy),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  bit         exp_busy_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'd4;
      1:       return 8'd255;
      default: return 8'((r * 9 + c) / 2);
    endcase
  endfunction

  function automatic logic [7:0] pix(input int mode, input int idx);
    case (mode)
      0:       return 8'd1;
      1:       return 8'd255;
      default: return 8'(idx);
    endcase
  endfunction

  task automatic push_frame_exp(input int mode);
    for (int r = 1; r <= 7; r++)
      for (int c = 1; c <= 7; c++)
        exp_q.push_back(exp_val(mode, r, c));
  endtask

  // ---------------- monitor ----------------
  int   acc_cnt = 0;
  int   acc20_cyc = -1;
  int   first_y_cyc = -1;
  int   done_cnt = 0;
  int   stall_cnt = 0;
  bit   prev_stall = 1'b0;
  bit   done_prev = 1'b0;
  logic [7:0] prev_y = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (x_valid && x_ready) begin
        if (acc_cnt == 20 && acc20_cyc < 0) acc20_cyc = cyc;
        acc_cnt++;
      end
      if (y_valid && first_y_cyc < 0) first_y_cyc = cyc;
      if (prev_stall) begin
        check("y_hold_valid", y_valid, 1);
        check("y_hold_value", y, prev_y);
      end
      if (y_valid && !y_ready) begin
        stall_cnt++;
        check("x_ready_in_stall", x_ready, 0);
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) check("extra_result", y, 32'hFFFF_FFFF);
        else check("y_result", y, exp_q.pop_front());
      end
      if (done_prev) begin
        if (exp_busy_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("busy_after_done", busy, exp_busy_q.pop_front());
      end
      done_prev = frame_done;
      if (frame_done) begin
        done_cnt++;
        check("done_on_handshake", y_valid && y_ready, 1);
      end
      prev_stall = y_valid && !y_ready;
      prev_y     = y;
    end
  end

  // ---------------- driver tasks ----------------
  bit bp_mode = 1'b0;

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        y_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        y_ready = 1'b1;
      end
    end
  end

  task automatic load_coef(input logic [3:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int n_pix, input bit rand_valid,
                            input int we_idx, input logic [3:0] we_addr,
                            input logic [7:0] we_data);
    for (int i = 0; i < n_pix; i++) begin
      if (rand_valid) begin
        int k;
        k = $urandom_range(0, 2);
        x_valid = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
      end
      x = pix(mode, i);
      x_valid = 1'b1;
      if (i == we_idx) begin
        coef_we = 1'b1; coef_addr = we_addr; coef_data = we_data;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!x_ready && n < 100) begin @(negedge clk); n++; end
        if (!x_ready) check("x_accept_timeout", x_ready, 1);
      end
      @(posedge clk); #1;
      coef_we = 1'b0;
    end
    x_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("results_outstanding", exp_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  // ---------------- test sequence ----------------
  int done_base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_x_ready", x_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // default coefficients, all ones -> 1119>>8 = 4
    done_base = done_cnt;
    push_frame_exp(0); exp_busy_q.push_back(1'b0);
    send_frame(0, 81, 1'b0, -1, 4'd0, 8'd0);
    drain(300);
    check("t1_first_latency", 32'(first_y_cyc - acc20_cyc), 2);
    check("t1_frame_done_count", done_cnt - done_base, 1);

    // saturation: 255*1119>>8 = 1114 -> 255
    done_base = done_cnt;
    push_frame_exp(1); exp_busy_q.push_back(1'b0);
    send_frame(1, 81, 1'b0, -1, 4'd0, 8'd0);
    drain(300);
    check("t2_frame_done_count", done_cnt - done_base, 1);

    // all coefficients zero, out-of-range write ignored, B22=128 written with pixel 0
    for (int a = 0; a < 9; a++) load_coef(4'(a), 8'd0);
    load_coef(4'd13, 8'd99);
    done_base = done_cnt;
    push_frame_exp(2); exp_busy_q.push_back(1'b0);
    send_frame(2, 81, 1'b0, 0, 4'd4, 8'd128);
    drain(300);
    check("t3_frame_done_count", done_cnt - done_base, 1);

    // backpressure with bubbles: same result sequence
    done_base = done_cnt;
    stall_cnt = 0;
    bp_mode = 1'b1;
    push_frame_exp(2); exp_busy_q.push_back(1'b0);
    send_frame(2, 81, 1'b1, -1, 4'd0, 8'd0);
    drain(2000);
    bp_mode = 1'b0;
    check("t4_frame_done_count", done_cnt - done_base, 1);
    check("t4_stalls_seen", stall_cnt > 0, 1);

    // mid-frame write of B22=0 ignored; two frames back to back
    done_base = done_cnt;
    push_frame_exp(2); push_frame_exp(2);
    exp_busy_q.push_back(1'b1); exp_busy_q.push_back(1'b0);
    send_frame(2, 81, 1'b0, 30, 4'd4, 8'd0);
    send_frame(2, 81, 1'b0, -1, 4'd0, 8'd0);
    drain(400);
    check("t5_frame_done_count", done_cnt - done_base, 2);

    // async reset after pixel 40, then a default-coefficient frame
    push_frame_exp(2);
    send_frame(2, 41, 1'b0, -1, 4'd0, 8'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_y_valid", y_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_y", y, 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_x_ready_after_rst", x_ready, 1);
    done_base = done_cnt;
    push_frame_exp(0); exp_busy_q.push_back(1'b0);
    send_frame(0, 81, 1'b0, -1, 4'd0, 8'd0);
    drain(300);
    check("t6_frame_done_count", done_cnt - done_base, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
